// File: rtl/bram_stream_reader.sv
// Read-side initiator for a single-port BRAM with 1-cycle registered read.
// Streams len_i words from base_addr_i onward over valid/ready with full backpressure.
module bram_stream_reader #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [RAM_ADDR_BITS-1:0] base_addr_i,
  input  logic [RAM_ADDR_BITS:0]   len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [RAM_ADDR_BITS-1:0] mem_addr_o,
  input  logic [RAM_WIDTH-1:0]     mem_data_i,
  output logic [RAM_WIDTH-1:0]     m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic                     m_last_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]               state_q;
  logic [RAM_ADDR_BITS-1:0] base_q;
  logic [RAM_ADDR_BITS:0]   len_q;
  logic [RAM_ADDR_BITS:0]   issued_q;
  logic [RAM_ADDR_BITS:0]   beats_q;
  logic [RAM_WIDTH-1:0]     fifo_q [2];
  logic                     wr_ptr_q;
  logic                     rd_ptr_q;
  logic [1:0]               occ_q;
  logic                     inflight_q;
  logic                     done_q;

  logic       pop;
  logic       push;
  logic       issue;
  logic       last_beat;
  logic [2:0] pending;

  assign pop  = m_valid_o & m_ready_i;
  // Read data returns exactly one cycle after issue, so the in-flight flag is the push strobe.
  assign push = inflight_q;

  // Slots already spoken for once this cycle's pop leaves; a new read needs one free slot.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = (state_q == S_READ) && (pending < 3'd2);

  assign mem_en_o   = issue;
  assign mem_we_o   = 1'b0;
  assign mem_addr_o = base_q + issued_q[RAM_ADDR_BITS-1:0];

  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = fifo_q[rd_ptr_q];
  assign m_last_o  = m_valid_o && (beats_q == len_q - 1'b1);
  assign last_beat = pop && m_last_o;

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      // NOTE: the two-entry buffer is reset because m_data_o must read 0 out of reset.
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              base_q   <= base_addr_i;
              len_q    <= len_i;
              issued_q <= '0;
              beats_q  <= '0;
              state_q  <= S_READ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (issue) begin
            issued_q <= issued_q + 1'b1;
            if (issued_q + 1'b1 == len_q) state_q <= S_DRAIN;
          end
        end
        default: ;
      endcase

      if (last_beat) begin
        state_q <= S_IDLE;
        done_q  <= 1'b1;
      end

      if (push) begin
        fifo_q[wr_ptr_q] <= mem_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        beats_q  <= beats_q + 1'b1;
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a behavioural 1-cycle BRAM preloaded with mem[i]=i.
`timescale 1ns/1ps
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len_v;
  logic        busy, done, mem_en, mem_we, m_valid, m_ready, m_last;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_q, m_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_stream_reader #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr), .len_i(len_v),
    .busy_o(busy), .done_o(done), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_i(mem_q), .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_last_o(m_last)
  );

  logic [7:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
  always @(posedge clk) if (mem_en) mem_q <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Protocol monitors sampled mid-cycle; they only accumulate counters checked later.
  int en_cnt = 0, valid_cnt = 0, done_cnt = 0, we_cnt = 0;
  int credit_err = 0, stab_err = 0, occ_err = 0;
  int occ_m = 0, infl_m = 0;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    int pop_m;
    pop_m = (m_valid && m_ready) ? 1 : 0;
    if (mem_en) en_cnt++;
    if (m_valid) valid_cnt++;
    if (done) done_cnt++;
    if (mem_we !== 1'b0) we_cnt++;
    if (rst_n === 1'b1) begin
      if (mem_en && (occ_m + infl_m - pop_m >= 2)) credit_err++;
      if (m_valid !== (occ_m != 0)) occ_err++;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_err++;
      occ_m  = occ_m + infl_m - pop_m;
      infl_m = mem_en ? 1 : 0;
      prev_stall = m_valid && !m_ready;
    end else begin
      occ_m = 0; infl_m = 0; prev_stall = 1'b0;
    end
    prev_data = m_data;
    prev_last = m_last;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one transfer from the post-edge drive point; returns at the post-edge point after done.
  task automatic run_xfer(input logic [9:0] base, input int len, input logic bp, input logic ign);
    logic [15:0] pat = 16'b1011_0010_1110_0101;
    logic [9:0]  a;
    int beats = 0, cyc, first_cyc = 0, last_cyc = 0, en0, done0;
    logic seen_valid = 1'b0;
    en0   = en_cnt;
    done0 = done_cnt;
    start = 1'b1; base_addr = base; len_v = len[10:0]; m_ready = 1'b1;
    tick();
    start = 1'b0; base_addr = 10'h155; len_v = 11'd7;
    cyc = 1;
    while (beats < len && cyc < 3000) begin
      if (ign && (cyc == 2 || cyc == 5)) begin
        start = 1'b1; base_addr = 10'h200; len_v = 11'd2;
      end else start = 1'b0;
      m_ready = bp ? pat[cyc % 16] : 1'b1;
      @(negedge clk);
      if (m_valid && !seen_valid) begin
        seen_valid = 1'b1;
        check("first_valid_latency", cyc, 3);
      end
      if (m_valid && m_ready) begin
        a = base + beats[9:0];
        check($sformatf("data[%0d]", beats), m_data, a[7:0]);
        check($sformatf("last[%0d]", beats), m_last, (beats == len - 1));
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      tick();
      cyc++;
    end
    if (beats < len) check("beat_timeout", beats, len);
    start = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    check("done_after_last", done, 1'b1);
    check("busy_falls_with_done", busy, 1'b0);
    tick();
    @(negedge clk);
    check("done_single_pulse", done_cnt - done0, 1);
    check("reads_issued", en_cnt - en0, len);
    if (!bp) check("consecutive_beats", last_cyc - first_cyc, len - 1);
    tick();
  endtask

  initial begin
    int en0, v0, d0, beats;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len_v = '0; m_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_en", mem_en, 1'b0);
    check("rst_addr", mem_addr, 10'h000);
    check("rst_valid", m_valid, 1'b0);
    check("rst_last", m_last, 1'b0);
    check("rst_data", m_data, 8'h00);
    check("rst_we", mem_we, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    run_xfer(10'h010, 4, 1'b0, 1'b0);
    run_xfer(10'h3FE, 4, 1'b0, 1'b0);
    run_xfer(10'h123, 8, 1'b1, 1'b0);
    run_xfer(10'h080, 8, 1'b0, 1'b1);

    // Zero-length command: a done pulse and nothing else.
    en0 = en_cnt; v0 = valid_cnt; d0 = done_cnt;
    start = 1'b1; base_addr = 10'h020; len_v = 11'd0;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("len0_done", done, 1'b1);
    check("len0_busy", busy, 1'b0);
    tick(); tick(); tick();
    @(negedge clk);
    check("len0_done_once", done_cnt - d0, 1);
    check("len0_no_reads", en_cnt - en0, 0);
    check("len0_no_valid", valid_cnt - v0, 0);
    tick();

    run_xfer(10'h000, 1024, 1'b0, 1'b0);

    // Reset in the middle of a stream aborts without a done pulse.
    start = 1'b1; base_addr = 10'h040; len_v = 11'd8; m_ready = 1'b1;
    tick();
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 50 && beats < 3; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) beats++;
      tick();
    end
    check("pre_reset_beats", beats, 3);
    d0 = done_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_valid", m_valid, 1'b0);
    check("abort_en", mem_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    v0 = valid_cnt;
    tick(); tick(); tick();
    @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_valid", valid_cnt - v0, 0);
    tick();

    run_xfer(10'h0A5, 3, 1'b1, 1'b0);

    check("we_never_high", we_cnt, 0);
    check("credit_respected", credit_err, 0);
    check("stall_stable", stab_err, 0);
    check("valid_matches_occupancy", occ_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side initiator for the single-port block RAM (1-cycle registered read, no-change write mode).
- On a start command, reads len_i consecutive words beginning at base_addr_i.
- Streams the words out on a valid/ready interface with full backpressure.
- Sits between a BRAM instance and a downstream consumer (UART TX, display, checker). Never writes the memory.

Parameters:
- RAM_WIDTH, 8, data word width; must match the BRAM.
- RAM_ADDR_BITS, 10, BRAM address width; depth is 2**RAM_ADDR_BITS.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  synchronous active-low reset.
- start_i  input  1  command strobe; sampled only in IDLE.
- base_addr_i  input  RAM_ADDR_BITS  first read address; captured with start_i.
- len_i  input  RAM_ADDR_BITS+1  number of words, 0..2**RAM_ADDR_BITS; captured with start_i.
- busy_o  output  1  high from the cycle after an accepted start until done_o.
- done_o  output  1  one-cycle pulse when the transfer completes.
- mem_en_o  output  1  BRAM enable.
- mem_we_o  output  1  BRAM write enable; constant 0.
- mem_addr_o  output  RAM_ADDR_BITS  BRAM address.
- mem_data_i  input  RAM_WIDTH  BRAM read data (data_o of the BRAM).
- m_data_o  output  RAM_WIDTH  stream data.
- m_valid_o  output  1  stream valid.
- m_ready_i  input  1  stream ready.
- m_last_o  output  1  high with the final word of a transfer.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - Outputs go to: busy_o=0, done_o=0, mem_en_o=0, mem_addr_o=0, m_valid_o=0, m_last_o=0, m_data_o=0.
  - State goes to IDLE; internal 2-entry buffer is emptied; the in-flight read flag is cleared.
  - Reset mid-transfer aborts immediately. No done_o pulse. Discarded words are never emitted.
- IDLE:
  - start_i=1 with len_i!=0: capture base_addr_i and len_i, go to READ.
  - start_i=1 with len_i=0: no memory access, no stream beats; done_o pulses the next cycle; stay in IDLE.
- READ (issuing reads):
  - A read is issued in a cycle when mem_en_o=1 with mem_addr_o = base + issued count.
  - Address arithmetic is modulo 2**RAM_ADDR_BITS, so reads wrap from the top address to 0.
  - Credit rule: issue only if (buffer occupancy + in-flight reads - pop this cycle) < 2. The buffer can never overflow.
  - mem_en_o is never asserted otherwise, so no-change BRAM output holding is never relied on.
  - The first read is issued the cycle after start is accepted.
  - After len reads have been issued, go to DRAIN.
- Capture path:
  - A read issued in cycle C presents data on mem_data_i in cycle C+1.
  - That data is pushed into the buffer at the end of C+1.
  - It appears on m_data_o/m_valid_o in C+2 if the buffer was empty.
  - First m_valid_o is therefore 3 cycles after the start edge.
- Stream handshake:
  - A beat transfers when m_valid_o && m_ready_i.
  - While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o are held stable.
  - m_valid_o never drops without a transfer.
  - Data is emitted in address order.
  - Simultaneous push and pop in one cycle is supported.
  - With m_ready_i held 1, sustained throughput is 1 word/clock.
- m_last_o is 1 exactly on beat number len (the final beat).
- DRAIN:
  - No reads are issued.
  - When the last beat transfers, done_o pulses the next cycle, busy_o falls in that same cycle, and the state returns to IDLE.
- start_i while busy is ignored; captured parameters cannot change mid-transfer.
- mem_we_o is 0 in all states, including reset.

Test Plan:
- Preload BRAM[i]=i; start, base=0x010, len=4, ready=1 -> first valid 3 cycles after start; data 0x10,0x11,0x12,0x13 on consecutive cycles; last on 0x13; done one cycle after; mem_we_o never 1.
- Wrap: base=0x3FE, len=4 -> reads addresses 0x3FE, 0x3FF, 0x000, 0x001; data 0xFE, 0xFF, 0x00, 0x01.
- Backpressure: len=8, ready toggled pseudo-randomly -> all 8 words in order, no duplicates or drops; data stable while stalled; mem_en_o never issues with buffer+in-flight already at 2.
- len=0 -> no mem_en_o, no valid; done_o pulses once the cycle after start. Full length len=1024 with ready=1 -> 1024 beats in 1024 consecutive cycles after the first.
- Start pulses during busy -> ignored; the transfer completes with the original base/len.
- rst_ni=0 in the middle of the stream -> next cycle valid=0, en=0, busy=0, no done. A new start then yields a correct fresh transfer.
